branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Pipelined, parametrised branch resolution stage for the RV32/RV64 core.
- Accepts one branch or JALR per handshake and evaluates the condition.
- Computes the actual target and compares it with the front-end prediction.
- Returns a registered resolution with redirect/mispredict to the fetch unit one cycle after acceptance.
- Sits between the execute-stage operand bypass and the PC-select / fetch-redirect logic.

Parameters:
XLEN, 32, operand and PC width (32 or 64)
ILEN_BYTES, 4, fall-through increment added to PC

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept request this cycle
in_rs1  in  XLEN  operand 1
in_rs2  in  XLEN  operand 2
in_func  in  3  branch func code (FNC_* encoding)
in_is_jalr  in  1  1 = JALR: unconditional, target from rs1
in_pc  in  XLEN  PC of branch
in_imm  in  XLEN  sign-extended offset
in_pred_taken  in  1  front-end predicted taken
in_pred_target  in  XLEN  front-end predicted target
out_valid  out  1  resolution valid
out_ready  in  1  consumer accepts resolution
out_taken  out  1  actual direction
out_target  out  XLEN  actual next PC
out_mispredict  out  1  redirect required
out_illegal  out  1  unsupported func code
flush  in  1  pipeline kill, synchronous

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_taken=0, out_target=0, out_mispredict=0, out_illegal=0. Stat counters clear when present.
- Ready rule: single-entry output register; in_ready = !out_valid | out_ready. in_ready is combinational and does not depend on in_valid.
- Accept: occurs when in_valid & in_ready. Results register on that edge; latency is 1 cycle. Back-to-back accepts at full throughput when out_ready=1.
- Hold: while out_valid & !out_ready, all out_* hold stable and no accept occurs.
- Retire: occurs when out_valid & out_ready and there is no new accept; out_valid then clears the next cycle.
- Conditions:
  - BEQ 000: rs1==rs2
  - BNE 001: rs1!=rs2
  - BLT 100: signed rs1<rs2
  - BGE 101: signed rs1>=rs2 (equal operands are taken)
  - BLTU 110: unsigned rs1<rs2
  - BGEU 111: unsigned rs1>=rs2
  - Codes 010 and 011 with in_is_jalr=0: out_taken=0, out_illegal=1, out_mispredict=in_pred_taken.
- JALR: in_func is ignored, out_taken=1, out_target=(rs1+imm) with bit0 cleared, out_illegal=0.
- Target: taken gives pc+imm; not taken gives pc+ILEN_BYTES. All addition is modulo 2^XLEN (wraps silently).
- Mispredict: (out_taken != pred_taken) | (out_taken & pred_taken & out_target != pred_target). The predicted target is ignored when both predicted and actual are not taken.
- Flush: clears out_valid on the next edge and suppresses any accept that cycle. Flush has priority over accept and hold. in_ready may still read 1 during the flush cycle; the request is dropped.
- Reset while out_valid=1: the result is discarded, no retire.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined: two 32-bit saturating counters are present.
  - stat_branches counts retired resolutions.
  - stat_mispredicts counts retired resolutions with out_mispredict=1.
  - Both are exposed as output ports and cleared by reset.
  - Flushed entries are not counted.
  - Counters saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package branch_pkg:
  - func enum with the FNC_* values above, matching opcode.vh
  - resolution struct {taken, target, mispredict, illegal}, parameterised by XLEN via localparam convention
- Sub-module branch_cmp (combinational):
  - inputs XLEN-wide rs1/rs2 and func
  - outputs cond and illegal
  - instantiated once

Test Plan:
- BGE equal operands: rs1=rs2=0x80000000, func=101, pc=0x100, imm=0x20, pred_taken=0 -> next cycle out_taken=1, out_target=0x120, out_mispredict=1.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1, then BLT, then BLTU -> BLT taken=1, BLTU taken=0. Likewise BGE=0, BGEU=1.
- JALR alignment: rs1=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 -> out_target=0x1004, out_mispredict=0. Repeating with pred_target=0x1008 -> out_mispredict=1.
- Backpressure: two requests, out_ready=0 for 3 cycles -> first result held stable, in_ready=0, second accepted on the cycle out_ready rises, results in order.
- Flush and wrap: pc=0xFFFFFFFC, BEQ not taken -> out_target=0x0. Asserting flush with out_valid=1 and a new in_valid -> out_valid=0 next cycle, no result emitted for either.
- Illegal/stats: func=010, pred_taken=1 -> out_illegal=1, out_mispredict=1. With BRANCH_STATS_EN, after 5 retires (2 mispredict) and 1 flushed entry -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for branch resolution: func codes and the registered result.
// Optional statistics counters are enabled with BRANCH_STATS_EN.
package branch_pkg;

    localparam int unsigned BR_XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FNC_BEQ  = 3'b000,
        FNC_BNE  = 3'b001,
        FNC_BLT  = 3'b100,
        FNC_BGE  = 3'b101,
        FNC_BLTU = 3'b110,
        FNC_BGEU = 3'b111
    } br_func_e;

    // Target is sized for the widest core; narrower builds use the low bits.
    typedef struct packed {
        logic                   taken;
        logic [BR_XLEN_MAX-1:0] target;
        logic                   mispredict;
        logic                   illegal;
    } br_res_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator.
// Unsupported func codes report illegal and a false condition.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_func,
    output logic            o_cond,
    output logic            o_illegal
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    always_comb begin
        o_cond    = 1'b0;
        o_illegal = 1'b0;
        case (i_func)
            FNC_BEQ:  o_cond = w_eq;
            FNC_BNE:  o_cond = !w_eq;
            FNC_BLT:  o_cond = w_lt;
            FNC_BGE:  o_cond = !w_lt;
            FNC_BLTU: o_cond = w_ltu;
            FNC_BGEU: o_cond = !w_ltu;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/JALR resolution stage with a single-entry registered output.
// Define BRANCH_STATS_EN to add saturating retire/mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ILEN_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [2:0]      in_func,
    input  logic            in_is_jalr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_mispredict,
    output logic            out_illegal,
    input  logic            flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    logic            r_valid;
    br_res_t         r_res;
    br_res_t         w_next;
    logic            w_cond;
    logic            w_cmp_illegal;
    logic            w_taken;
    logic            w_fire;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_tgt;
    logic            w_unused;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .i_rs1     (in_rs1),
        .i_rs2     (in_rs2),
        .i_func    (in_func),
        .o_cond    (w_cond),
        .o_illegal (w_cmp_illegal)
    );

    assign in_ready   = !r_valid || out_ready;
    assign w_fire     = in_valid && in_ready && !flush;
    assign w_jalr_sum = in_rs1 + in_imm;
    assign w_taken    = in_is_jalr || w_cond;

    always_comb begin
        w_tgt = in_pc + XLEN'(ILEN_BYTES);
        if (in_is_jalr)
            w_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};
        else if (w_cond)
            w_tgt = in_pc + in_imm;
    end

    always_comb begin
        w_next            = '0;
        w_next.taken      = w_taken;
        w_next.target     = BR_XLEN_MAX'(w_tgt);
        w_next.illegal    = !in_is_jalr && w_cmp_illegal;
        // Predicted target only matters when both sides say taken.
        w_next.mispredict = (w_taken != in_pred_taken)
                         || (w_taken && in_pred_taken
                             && (w_tgt != in_pred_target));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_res   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_res   <= w_next;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid      = r_valid;
    assign out_taken      = r_res.taken;
    assign out_target     = r_res.target[XLEN-1:0];
    assign out_mispredict = r_res.mispredict;
    assign out_illegal    = r_res.illegal;
    assign w_unused       = ^r_res.target;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mis;
    logic        w_retire;

    assign w_retire = r_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else if (w_retire) begin
            if (r_stat_br != '1)
                r_stat_br <= r_stat_br + 32'd1;
            if (r_res.mispredict && (r_stat_mis != '1))
                r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (XLEN=32).
// Directed plan cases followed by randomized traffic against a queue model.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [2:0]  in_func;
    logic        in_is_jalr;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_target;
    logic        out_mispredict;
    logic        out_illegal;
    logic        flush;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        t;
        logic [31:0] tg;
        logic        m;
        logic        il;
    } exp_t;

    branch_resolve_unit #(.XLEN(32), .ILEN_BYTES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_func        (in_func),
        .in_is_jalr     (in_is_jalr),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal),
        .flush          (flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(
        input logic [31:0] rs1, input logic [31:0] rs2,
        input logic [2:0] f, input logic j,
        input logic [31:0] pc, input logic [31:0] imm,
        input logic pt, input logic [31:0] ptg);
        exp_t e;
        e.il = 1'b0;
        e.t  = 1'b0;
        if (j) begin
            e.t  = 1'b1;
            e.tg = (rs1 + imm) & 32'hFFFF_FFFE;
        end else begin
            case (f)
                3'd0: e.t = (rs1 == rs2);
                3'd1: e.t = (rs1 != rs2);
                3'd4: e.t = ($signed(rs1) < $signed(rs2));
                3'd5: e.t = ($signed(rs1) >= $signed(rs2));
                3'd6: e.t = (rs1 < rs2);
                3'd7: e.t = (rs1 >= rs2);
                default: e.il = 1'b1;
            endcase
            e.tg = e.t ? pc + imm : pc + 32'd4;
        end
        e.m = (e.t != pt) || (e.t && pt && e.tg != ptg);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(
        input logic [31:0] rs1, input logic [31:0] rs2,
        input logic [2:0] f, input logic j,
        input logic [31:0] pc, input logic [31:0] imm,
        input logic pt, input logic [31:0] ptg);
        in_rs1 = rs1; in_rs2 = rs2; in_func = f;
        in_is_jalr = j; in_pc = pc; in_imm = imm;
        in_pred_taken = pt; in_pred_target = ptg;
    endtask

    task automatic chk_res(input string tag, input exp_t e);
        chk({tag, ".v"},  {31'd0, out_valid}, 32'd1);
        chk({tag, ".t"},  {31'd0, out_taken}, {31'd0, e.t});
        chk({tag, ".tg"}, out_target, e.tg);
        chk({tag, ".m"},  {31'd0, out_mispredict}, {31'd0, e.m});
        chk({tag, ".il"}, {31'd0, out_illegal}, {31'd0, e.il});
    endtask

    // One accepted request with out_ready=1; result checked after the edge.
    task automatic send(
        input string tag,
        input logic [31:0] rs1, input logic [31:0] rs2,
        input logic [2:0] f, input logic j,
        input logic [31:0] pc, input logic [31:0] imm,
        input logic pt, input logic [31:0] ptg);
        exp_t e;
        drive(rs1, rs2, f, j, pc, imm, pt, ptg);
        e = model(rs1, rs2, f, j, pc, imm, pt, ptg);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_res(tag, e);
    endtask

    exp_t q[$];
    exp_t ea;
    exp_t eb;

    initial begin
        int exp_br;
        int exp_mis;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        drive('0, '0, 3'd0, 1'b0, '0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.v",  {31'd0, out_valid}, 32'd0);
        chk("rst.t",  {31'd0, out_taken}, 32'd0);
        chk("rst.tg", out_target, 32'd0);
        chk("rst.m",  {31'd0, out_mispredict}, 32'd0);
        chk("rst.il", {31'd0, out_illegal}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send("bge_eq", 32'h8000_0000, 32'h8000_0000, 3'b101, 1'b0,
             32'h100, 32'h20, 1'b0, 32'h0);
        chk("bge_eq.lit_t",  {31'd0, out_taken}, 32'd1);
        chk("bge_eq.lit_tg", out_target, 32'h120);
        chk("bge_eq.lit_m",  {31'd0, out_mispredict}, 32'd1);

        send("blt",  32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0,
             32'h200, 32'h40, 1'b0, 32'h0);
        chk("blt.lit", {31'd0, out_taken}, 32'd1);
        send("bltu", 32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0,
             32'h200, 32'h40, 1'b0, 32'h0);
        chk("bltu.lit", {31'd0, out_taken}, 32'd0);
        send("bge",  32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0,
             32'h200, 32'h40, 1'b0, 32'h0);
        chk("bge.lit", {31'd0, out_taken}, 32'd0);
        send("bgeu", 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b0,
             32'h200, 32'h40, 1'b0, 32'h0);
        chk("bgeu.lit", {31'd0, out_taken}, 32'd1);

        send("jalr_ok", 32'h1001, 32'h0, 3'b000, 1'b1,
             32'h500, 32'h4, 1'b1, 32'h1004);
        chk("jalr_ok.lit_tg", out_target, 32'h1004);
        chk("jalr_ok.lit_m", {31'd0, out_mispredict}, 32'd0);
        send("jalr_bad", 32'h1001, 32'h0, 3'b011, 1'b1,
             32'h500, 32'h4, 1'b1, 32'h1008);
        chk("jalr_bad.lit_m", {31'd0, out_mispredict}, 32'd1);

        send("ill", 32'h5, 32'h5, 3'b010, 1'b0,
             32'h300, 32'h8, 1'b1, 32'h308);
        chk("ill.lit_il", {31'd0, out_illegal}, 32'd1);
        chk("ill.lit_m",  {31'd0, out_mispredict}, 32'd1);

        send("wrap", 32'd1, 32'd2, 3'b000, 1'b0,
             32'hFFFF_FFFC, 32'h10, 1'b0, 32'h0);
        chk("wrap.lit_tg", out_target, 32'h0);

        // Backpressure: A held for three stalled cycles, B waits.
        @(posedge clk); #1;
        drive(32'd3, 32'd4, 3'b001, 1'b0, 32'h1000, 32'h80, 1'b1, 32'h1080);
        ea = model(32'd3, 32'd4, 3'b001, 1'b0, 32'h1000, 32'h80, 1'b1,
                   32'h1080);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        drive(32'd7, 32'd7, 3'b100, 1'b0, 32'h2000, 32'h10, 1'b1, 32'h2010);
        eb = model(32'd7, 32'd7, 3'b100, 1'b0, 32'h2000, 32'h10, 1'b1,
                   32'h2010);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.rdy0", {31'd0, in_ready}, 32'd0);
            chk_res("bp.holdA", ea);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
        chk_res("bp.lastA", ea);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_res("bp.B", eb);
        @(posedge clk); #1;
        chk("bp.drain", {31'd0, out_valid}, 32'd0);

        // Flush with a held result and a new request in the same cycle.
        drive(32'd1, 32'd1, 3'b000, 1'b0, 32'h40, 32'h8, 1'b0, 32'h0);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("fl.pre", {31'd0, out_valid}, 32'd1);
        drive(32'd1, 32'd2, 3'b001, 1'b0, 32'h80, 32'h8, 1'b0, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("fl.kill", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("fl.none", {31'd0, out_valid}, 32'd0);

        // Randomized traffic; reset first so counters start clean.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
`ifdef BRANCH_STATS_EN
        chk("st.rst_b", stat_branches, 32'd0);
        chk("st.rst_m", stat_mispredicts, 32'd0);
`endif
        exp_br = 0; exp_mis = 0;
        for (int c = 0; c < 400; c++) begin
            logic [31:0] r1, r2, pc, imm, ptg;
            logic [2:0]  f;
            logic        j, pt;
            exp_t        e;
            logic        er;
            r1  = $urandom;
            r2  = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            f   = 3'($urandom_range(0, 7));
            j   = ($urandom_range(0, 7) == 0);
            pc  = $urandom;
            imm = $urandom;
            pt  = 1'($urandom_range(0, 1));
            e   = model(r1, r2, f, j, pc, imm, pt, 32'h0);
            ptg = ($urandom_range(0, 1) == 1) ? e.tg : $urandom;
            e   = model(r1, r2, f, j, pc, imm, pt, ptg);
            drive(r1, r2, f, j, pc, imm, pt, ptg);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            er = (q.size() == 0) || out_ready;
            chk("rnd.rdy", {31'd0, in_ready}, {31'd0, er});
            chk("rnd.v", {31'd0, out_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) chk_res("rnd", q[0]);
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) begin
                    exp_br++;
                    if (q[0].m) exp_mis++;
                    void'(q.pop_front());
                end
                if (in_valid && er) q.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        if (q.size() != 0) begin
            exp_br++;
            if (q[0].m) exp_mis++;
            void'(q.pop_front());
        end
        @(posedge clk); #1;
        chk("rnd.drain", {31'd0, out_valid}, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("st.br",  stat_branches, 32'(exp_br));
        chk("st.mis", stat_mispredicts, 32'(exp_mis));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
